if_prefetch_unit: RTL

- Parametrised instruction-fetch unit with cache lookup, byte-serial miss refill and an instruction prefetch queue feeding decode.
- Sits between the PC/branch logic of EX and the decode stage. Shares the byte-wide memory port with MEM through the arbiter's busy signal.
- Generalises single-instruction fetch to a QDEPTH-deep queue and INST_BYTES-wide words. Memory-busy cycles never force resending an already accepted byte.

---
 rtl/if_prefetch_unit_pkg.sv | 11 +
 rtl/if_inst_queue.sv | 49 ++++
 rtl/if_prefetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch / prefetch unit.
package if_prefetch_unit_pkg;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } fetch_state_e;

  localparam logic [31:0] ZeroWord = 32'h0;
endpackage

// File: rtl/if_inst_queue.sv
// Circular prefetch FIFO; flush wins over push/pop, full is judged on count before pop.
module if_inst_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               rd_ptr, wr_ptr;
  logic                        do_push, do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch: cache lookup, byte-serial miss refill, prefetch queue to decode.
// Cache path enabled by defining IF_CACHE_EN; otherwise every fetch refills from memory.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                INST_BYTES = 4,
  parameter int                QDEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect_valid_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  input  logic                    mem_busy_i,
  input  logic [7:0]              mem_byte_i,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [ADDR_W-1:0]       cache_raddr_o,
  input  logic                    cache_hit_i,
  input  logic [8*INST_BYTES-1:0] cache_inst_i,
  output logic                    cache_we_o,
  output logic [ADDR_W-1:0]       cache_waddr_o,
  output logic [8*INST_BYTES-1:0] cache_wdata_o,
  output logic                    inst_valid_o,
  output logic [8*INST_BYTES-1:0] inst_o,
  output logic [ADDR_W-1:0]       inst_pc_o,
  input  logic                    inst_ready_i
);
  localparam int IW    = 8 * INST_BYTES;
  localparam int CNT_W = $clog2(INST_BYTES + 1);
  localparam int QCW   = $clog2(QDEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              cap_pending;
  logic [IW-1:0]     word_q;
  logic              hit;
  logic [IW-1:0]     hit_data;
  logic [QCW-1:0]    q_count;
  logic [ADDR_W+IW-1:0] q_head;
  logic              q_full, push, accept, refill_done;
  logic [IW-1:0]     push_inst;

`ifdef IF_CACHE_EN
  assign hit      = cache_hit_i;
  assign hit_data = cache_inst_i;
`else
  logic unused_cache;
  assign unused_cache = ^{cache_hit_i, cache_inst_i};
  assign hit      = 1'b0;
  assign hit_data = ZeroWord[IW-1:0];
`endif

  assign q_full      = q_count >= QCW'(QDEPTH);
  assign refill_done = (state_q == REFILL) && (recv_cnt == CNT_W'(INST_BYTES));
  assign mem_req_o   = (state_q == REFILL) && (issue_cnt < CNT_W'(INST_BYTES));
  assign mem_addr_o  = fetch_pc + ADDR_W'(issue_cnt);
  assign accept      = mem_req_o && !mem_busy_i;
  assign push_inst   = (state_q == LOOKUP) ? hit_data : word_q;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      LOOKUP: if (!q_full) begin
        if (hit) push = 1'b1;
        else     state_d = REFILL;
      end
      REFILL: if (refill_done) begin
        push    = 1'b1;
        state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
    // Redirect drops any same-cycle push; the queue is flushed anyway.
    if (redirect_valid_i) begin
      push    = 1'b0;
      state_d = LOOKUP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOOKUP;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      cap_pending <= 1'b0;
      word_q      <= '0;
    end else if (redirect_valid_i) begin
      // Clearing cap_pending discards the byte of an address accepted this cycle.
      fetch_pc    <= redirect_pc_i;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      cap_pending <= 1'b0;
    end else begin
      cap_pending <= accept;
      if (accept) issue_cnt <= issue_cnt + 1'b1;
      if (cap_pending) begin
        for (int b = 0; b < INST_BYTES; b++)
          if (recv_cnt == CNT_W'(b)) word_q[8*b +: 8] <= mem_byte_i;
        recv_cnt <= recv_cnt + 1'b1;
      end
      if (push) fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
      if (refill_done) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
    end
  end

  if_inst_queue #(
    .WIDTH (ADDR_W + IW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({fetch_pc, push_inst}),
    .pop       (inst_valid_o && inst_ready_i),
    .flush     (redirect_valid_i),
    .count     (q_count),
    .head      (q_head)
  );

  assign inst_valid_o = (q_count != '0);
  assign inst_o       = q_head[IW-1:0];
  assign inst_pc_o    = q_head[IW +: ADDR_W];

`ifdef IF_CACHE_EN
  // Fill is written even on a redirect: the data is correct for its address.
  assign cache_raddr_o = fetch_pc;
  assign cache_we_o    = refill_done;
  assign cache_waddr_o = refill_done ? fetch_pc : '0;
  assign cache_wdata_o = refill_done ? word_q : '0;
`else
  assign cache_raddr_o = '0;
  assign cache_we_o    = 1'b0;
  assign cache_waddr_o = '0;
  assign cache_wdata_o = ZeroWord[IW-1:0];
`endif
endmodule
